// File: rtl/gpu_bram_ctl.sv
// Simple-dual-port GPU table RAM: per-byte writes, collision bypass, clear-sweep engine.
// Read latency 1+OUT_REG cycles; no backpressure, reads and writes accepted every cycle.
module gpu_bram_ctl #(
   parameter int ADDR_WIDTH = 10,
   parameter int SIZE = 1024,
   parameter int DATA_WIDTH = 64,
   parameter int OUT_REG = 0,
   parameter int BYPASS = 1,
   parameter int CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   output logic                    busy,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   mem_dout_addr,
   output logic [DATA_WIDTH-1:0]   mem_dout,
   output logic                    mem_dout_valid,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   mem_din_addr,
   input  logic [DATA_WIDTH-1:0]   mem_din,
   input  logic [DATA_WIDTH/8-1:0] mem_din_be
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem [0:SIZE-1];

   logic                  wr_ok, rd_oor, coll;
   logic [DATA_WIDTH-1:0] rd_raw, rd_word, out_q;
   logic                  vld1_q, busy1_q, oor1_q, coll1_q;
   logic [DATA_WIDTH-1:0] din1_q;
   logic [NB-1:0]         be1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   assign busy   = (state_q == CLEAR);
   assign wr_ok  = we && !busy && ({1'b0, mem_din_addr} < SIZE_W);
   assign rd_oor = !({1'b0, mem_dout_addr} < SIZE_W);
   assign coll   = re && wr_ok && (mem_dout_addr == mem_din_addr);

   // Reset must leave the array untouched, so both write sources are gated by it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem[cnt_q[IW-1:0]] <= CLEAR_VALUE;
         end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
               if (mem_din_be[b]) mem[mem_din_addr[IW-1:0]][8*b +: 8] <= mem_din[8*b +: 8];
            end
         end
      end
      rd_raw <= mem[mem_dout_addr[IW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld1_q  <= 1'b0;
         busy1_q <= 1'b0;
         oor1_q  <= 1'b0;
         coll1_q <= 1'b0;
         din1_q  <= '0;
         be1_q   <= '0;
      end else begin
         vld1_q  <= re;
         busy1_q <= busy;
         oor1_q  <= rd_oor;
         coll1_q <= coll;
         din1_q  <= mem_din;
         be1_q   <= mem_din_be;
      end
   end

   // The array read returns the pre-write word; bypass overlays the written lanes.
   always_comb begin
      rd_word = rd_raw;
      if ((BYPASS != 0) && coll1_q) begin
         for (int b = 0; b < NB; b++) begin
            if (be1_q[b]) rd_word[8*b +: 8] = din1_q[8*b +: 8];
         end
      end
      if (oor1_q)  rd_word = '0;
      if (busy1_q) rd_word = CLEAR_VALUE;
   end

   always_ff @(posedge clk) begin
      if (reset)       out_q <= '0;
      else if (vld1_q) out_q <= rd_word;
   end

   if (OUT_REG != 0) begin : g_oreg
      logic vld2_q;
      always_ff @(posedge clk) begin
         if (reset) vld2_q <= 1'b0;
         else       vld2_q <= vld1_q;
      end
      assign mem_dout       = out_q;
      assign mem_dout_valid = vld2_q;
   end else begin : g_noreg
      assign mem_dout       = vld1_q ? rd_word : out_q;
      assign mem_dout_valid = vld1_q;
   end
endmodule
